// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART TX serializer
//
// Ports:
//   clk_baud      baud clock, all logic on the rising edge
//   rst           asynchronous active-low reset
//   req_valid     per-requester byte valid (hold with stable data until ready)
//   req_data      requester i byte at [i*DATA_W +: DATA_W]
//   req_ready     one-hot accept, only ever high while idle
//   tx_start      one-cycle start strobe to the serializer
//   tx_data       byte to the serializer, held until the next grant
//   tx_busy       serializer frame in progress
//   grant_id      requester currently owning the serializer
//   arb_busy      high whenever the arbiter is not idle
//   tx_done       one-cycle pulse when the owned frame completes
//   err_timeout   one-cycle pulse when the serializer never reported busy
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int START_TO = 16
) (
  input  logic                     clk_baud,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     arb_busy,
  output logic                     tx_done,
  output logic                     err_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(START_TO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [WD_W-1:0]   wd_cnt;

  logic              found;
  logic [IDX_W-1:0]  winner;
  logic [DATA_W-1:0] win_data;
  logic [IDX_W-1:0]  next_ptr;

  // Search upward from rr_ptr, wrapping modulo N_REQ; the first valid wins.
  // The index carries one extra bit so rr_ptr + offset never overflows
  // before the wrap subtraction.
  always_comb begin
    logic [IDX_W:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(N_REQ)) begin
        idx = idx - (IDX_W+1)'(N_REQ);
      end
      if (!found && req_valid[idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

  assign win_data = req_data[winner*DATA_W +: DATA_W];

  // Priority rotates to the requester just after the one that was served,
  // whether its frame completed or its start timed out.
  assign next_ptr = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

  // Gated by rst so ready is low for the whole reset, not just after the
  // first edge.
  always_comb begin
    req_ready = '0;
    if (rst && state == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign arb_busy = (state != IDLE);

  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      tx_done     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= win_data;
            grant_id <= winner;
            tx_start <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          tx_start <= 1'b0;
          wd_cnt   <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A busy arriving on the expiry cycle still counts as a start.
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wd_cnt == WD_W'(START_TO - 1)) begin
            err_timeout <= 1'b1;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            tx_done <= 1'b1;
            rr_ptr  <= next_ptr;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int START_TO = 16;

  logic              clk_baud = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_busy = 1'b0;
  logic [1:0]        grant_id;
  logic              arb_busy;
  logic              tx_done;
  logic              err_timeout;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .START_TO(START_TO)) dut (
    .clk_baud    (clk_baud),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .tx_done     (tx_done),
    .err_timeout (err_timeout)
  );

  always #5 clk_baud = ~clk_baud;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model: owner -1 means free; events are stamped in cycles
  int        m_owner = -1;
  int        m_ptr = 0;
  int        m_gid = 0;
  logic [7:0] m_data = '0;
  int        m_start_cyc = -1;
  int        m_done_cyc = -1;
  int        m_to_cyc = -1;
  bit        m_framing = 0;

  // environment: requesters and serializer
  bit        pend [N];
  logic [7:0] pdata [N];
  bit        hs [N];
  bit        refill = 0, rand_req = 0, cfg_rand = 0;
  int        cfg_delay = 0, cfg_len = 1;
  bit        start_seen = 0, ser_active = 0;
  int        wait_left = 0, len_left = 0;

  // observations of the DUT for the directed literal checks
  int        log_gid[$];
  int        log_dat[$];
  int        log_cyc[$];
  int        done_cnt = 0, to_cnt = 0;
  int        last_done_cyc = -1, first_to_cyc = -1, last_ready_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int lg(input int i);
    return (i < log_gid.size()) ? log_gid[i] : -1;
  endfunction
  function automatic int ld(input int i);
    return (i < log_dat.size()) ? log_dat[i] : -1;
  endfunction
  function automatic int lc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -1;
  endfunction

  task automatic compare_and_advance();
    int w;
    logic [N-1:0] er;
    bit es, eb, ed, et;
    cyc++;
    if (!rst) begin
      m_owner = -1; m_ptr = 0; m_gid = 0; m_data = '0;
      m_start_cyc = -1; m_done_cyc = -1; m_to_cyc = -1; m_framing = 0;
    end
    w  = (rst && m_owner < 0) ? pick(req_valid, m_ptr) : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    es = (m_owner >= 0) && (cyc == m_start_cyc);
    eb = (m_owner >= 0);
    ed = (cyc == m_done_cyc);
    et = (cyc == m_to_cyc);

    chk("req_ready",   32'(req_ready),   32'(er));
    chk("tx_start",    32'(tx_start),    32'(es));
    chk("tx_data",     32'(tx_data),     32'(m_data));
    chk("grant_id",    32'(grant_id),    m_gid);
    chk("arb_busy",    32'(arb_busy),    32'(eb));
    chk("tx_done",     32'(tx_done),     32'(ed));
    chk("err_timeout", 32'(err_timeout), 32'(et));

    if (tx_start === 1'b1) begin
      log_gid.push_back(int'(grant_id));
      log_dat.push_back(int'(tx_data));
      log_cyc.push_back(cyc);
      start_seen = 1;
    end
    if (tx_done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
    if (err_timeout === 1'b1) begin
      to_cnt++;
      if (first_to_cyc < 0) first_to_cyc = cyc;
    end
    if (|req_ready) last_ready_cyc = cyc;

    if (rst) begin
      if (w >= 0) begin
        m_owner = w; m_gid = w; m_data = req_data[w*DW +: DW];
        m_start_cyc = cyc + 1; m_framing = 0; hs[w] = 1;
      end else if (m_owner >= 0 && cyc > m_start_cyc) begin
        if (m_framing) begin
          if (!tx_busy) begin
            m_done_cyc = cyc + 1; m_ptr = (m_owner + 1) % N; m_owner = -1;
          end
        end else if (tx_busy) begin
          m_framing = 1;
        end else if (cyc == m_start_cyc + START_TO) begin
          m_to_cyc = cyc + 1; m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
      end
    end
  endtask

  task automatic drive_ser();
    int r;
    if (start_seen) begin
      start_seen = 0;
      ser_active = 1;
      if (cfg_rand) begin
        r = int'($urandom_range(0, 19));
        if (r == 0)     wait_left = 1000;
        else if (r < 3) wait_left = START_TO - 1;
        else            wait_left = int'($urandom_range(0, 4));
        len_left = int'($urandom_range(1, 10));
      end else begin
        wait_left = cfg_delay;
        len_left  = cfg_len;
      end
    end
    if (ser_active) begin
      if (wait_left > 0) begin tx_busy = 1'b0; wait_left--; end
      else if (len_left > 0) begin tx_busy = 1'b1; len_left--; end
      else begin tx_busy = 1'b0; ser_active = 0; end
    end else begin
      tx_busy = 1'b0;
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        hs[i] = 0;
        if (!refill) pend[i] = 0;
      end
      if (rand_req) begin
        if (!pend[i] && $urandom_range(0, 99) < 30) begin
          pend[i] = 1; pdata[i] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 99) < 3) begin
          pend[i] = 0;
        end
      end
      req_valid[i] = pend[i];
      req_data[i*DW +: DW] = pend[i] ? pdata[i] : 8'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk_baud);
    compare_and_advance();
    @(posedge clk_baud);
    #1;
    drive_ser();
    drive_req();
  endtask

  task automatic clear_logs();
    log_gid.delete(); log_dat.delete(); log_cyc.delete();
    done_cnt = 0; to_cnt = 0;
    last_done_cyc = -1; first_to_cyc = -1; last_ready_cyc = -1;
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) begin pend[i] = 0; hs[i] = 0; end
    refill = 0; rand_req = 0; cfg_rand = 0;
    cfg_delay = 0; cfg_len = 1;
    start_seen = 0; ser_active = 0; tx_busy = 1'b0;
  endtask

  // Holds every requester valid through reset so ready is seen gated low.
  task automatic do_reset();
    rst = 1'b0;
    clear_env();
    for (int i = 0; i < N; i++) begin pend[i] = 1; pdata[i] = 8'($urandom); end
    drive_req();
    repeat (3) step();
    chk("rst_ready_gated", 32'(req_ready), 32'd0);
    for (int i = 0; i < N; i++) pend[i] = 0;
    req_valid = '0;
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (log_gid.size() < n && b < budget) begin
      step();
      b++;
    end
    chk(name, log_gid.size(), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_rr [5];
    int exp_wr [3];
    exp_rr = '{0, 1, 2, 3, 0};
    exp_wr = '{3, 0, 3};

    // single request
    do_reset();
    cfg_delay = 2; cfg_len = 10;
    pend[0] = 1; pdata[0] = 8'h55;
    drive_req();
    run_until(1, 10, "single_wait");
    repeat (16) step();
    chk("single_gid", lg(0), 0);
    chk("single_data", ld(0), 32'h55);
    chk("single_ready_to_start", lc(0) - last_ready_cyc, 1);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_done_lat", last_done_cyc - lc(0), 14);

    // round-robin with all four continuously valid
    do_reset();
    cfg_delay = 0; cfg_len = 2; refill = 1;
    for (int i = 0; i < N; i++) begin pend[i] = 1; pdata[i] = 8'(8'hA0 + i); end
    drive_req();
    run_until(5, 80, "rr_wait");
    refill = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    drive_req();
    repeat (8) step();
    for (int i = 0; i < 5; i++) begin
      chk("rr_gid", lg(i), exp_rr[i]);
      chk("rr_data", ld(i), 32'hA0 + exp_rr[i]);
    end

    // pointer wrap
    do_reset();
    cfg_delay = 0; cfg_len = 2;
    pend[3] = 1; pdata[3] = 8'hD3;
    drive_req();
    run_until(1, 10, "wrap_first");
    repeat (6) step();
    pend[0] = 1; pdata[0] = 8'hD0;
    pend[3] = 1; pdata[3] = 8'hD3;
    drive_req();
    run_until(3, 40, "wrap_wait");
    repeat (6) step();
    for (int i = 0; i < 3; i++) chk("wrap_gid", lg(i), exp_wr[i]);

    // watchdog: serializer never reports busy
    do_reset();
    cfg_delay = 1000; cfg_len = 1;
    pend[1] = 1; pdata[1] = 8'h11;
    pend[2] = 1; pdata[2] = 8'h22;
    drive_req();
    run_until(2, 40, "wd_wait");
    repeat (20) step();
    chk("wd_gid0", lg(0), 1);
    chk("wd_gid1", lg(1), 2);
    chk("wd_latency", first_to_cyc - lc(0), START_TO + 1);
    chk("wd_regrant", lc(1) - first_to_cyc, 1);
    chk("wd_to_cnt", to_cnt, 2);
    chk("wd_done_cnt", done_cnt, 0);

    // busy rises exactly on the expiry cycle
    do_reset();
    cfg_delay = START_TO - 1; cfg_len = 3;
    pend[0] = 1; pdata[0] = 8'h42;
    drive_req();
    run_until(1, 10, "late_wait");
    repeat (24) step();
    chk("late_to_cnt", to_cnt, 0);
    chk("late_done_cnt", done_cnt, 1);
    chk("late_done_lat", last_done_cyc - lc(0), 20);

    // reset while tx_start is high
    do_reset();
    pend[1] = 1; pdata[1] = 8'h3C;
    drive_req();
    step();
    chk("issue_start_high", 32'(tx_start), 32'd1);
    #1 rst = 1'b0;
    #1 chk("issue_start_drop", 32'(tx_start), 32'd0);

    // reset mid-frame, then a pending request on 2 wins from rr_ptr=0
    do_reset();
    cfg_delay = 0; cfg_len = 30;
    pend[0] = 1; pdata[0] = 8'h5A;
    drive_req();
    repeat (6) step();
    chk("mid_pre_busy", 32'(arb_busy), 32'd1);
    pend[2] = 1; pdata[2] = 8'h77;
    drive_req();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_done", 32'(tx_done), 32'd0);
    chk("mid_rst_to", 32'(err_timeout), 32'd0);
    chk("mid_rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'd0);
    ser_active = 0; start_seen = 0; tx_busy = 1'b0;
    cfg_delay = 0; cfg_len = 2;
    repeat (2) step();
    clear_logs();
    rst = 1'b1;
    run_until(1, 10, "mid_regrant_wait");
    repeat (6) step();
    chk("mid_regrant_gid", lg(0), 2);
    chk("mid_regrant_data", ld(0), 32'h77);

    // randomized traffic
    do_reset();
    cfg_rand = 1; rand_req = 1;
    repeat (3000) step();
    chk("rand_activity", 32'(log_gid.size() > 50), 32'd1);
    rand_req = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    drive_req();
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit serializer (start bit, 8 data bits, parity, stop) between N_REQ byte producers.
- Grants are round-robin; the block holds one requester's byte until the serializer finishes the frame, then rotates priority.
- Sits between the producers and the serializer's start/data/busy interface, all on the baud clock domain.
- Includes a start watchdog: if the serializer never reports busy, the block recovers and flags an error.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- START_TO, 16, max cycles after tx_start to wait for tx_busy before declaring timeout (>=2).

Ports:
- clk_baud  input  1  baud clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester byte valid; must stay high with stable data until its ready.
- req_data  input  N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W].
- req_ready  output  N_REQ  one-hot accept; transfer occurs when req_valid[i] && req_ready[i] at a clock edge.
- tx_start  output  1  one-cycle start strobe to the serializer.
- tx_data  output  DATA_W  byte to the serializer; stable from tx_start until return to IDLE.
- tx_busy  input  1  serializer frame in progress.
- grant_id  output  clog2(N_REQ)  index of the requester currently owning the serializer.
- arb_busy  output  1  high whenever state != IDLE.
- tx_done  output  1  one-cycle pulse when the owned frame completes.
- err_timeout  output  1  one-cycle pulse when the start watchdog expires.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, rr_ptr=0, wd_cnt=0, tx_start=0, tx_data=0, grant_id=0, tx_done=0, err_timeout=0. req_ready is combinationally 0 in reset.
- Reset mid-frame: tx_start drops immediately; the serializer is not told to abort; the pending byte is lost.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE arbitration:
  - Combinational search from rr_ptr upward, wrapping modulo N_REQ; the first i with req_valid[i]=1 wins.
  - req_ready[winner]=1, all other ready bits 0, in the same cycle.
  - At the edge: tx_data<=winner byte, grant_id<=winner, state->ISSUE.
  - No valid requests: stay IDLE with req_ready=0.
  - req_ready is never high outside IDLE.
- ISSUE: tx_start=1 for exactly this one cycle; wd_cnt<=0; ->WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise wd_cnt++. When wd_cnt==START_TO-1 and tx_busy=0: err_timeout pulses next cycle, rr_ptr<=grant_id+1 mod N_REQ, ->IDLE.
  - tx_busy=1 on the expiry cycle takes priority: no timeout.
- WAIT_DONE: stay while tx_busy=1. On tx_busy=0: tx_done pulses next cycle, rr_ptr<=grant_id+1 mod N_REQ, ->IDLE.
- Latency:
  - Handshake edge k: tx_start high in cycle k+1.
  - Earliest next grant is the cycle after return to IDLE, so one idle cycle minimum between frames.
- Requests arriving during WAIT_* are only registered as valid levels; no acceptance until IDLE.
- A requester dropping req_valid before ready loses its turn without error.
- tx_data and grant_id hold their values through IDLE until the next grant.
- wd_cnt width is clog2(START_TO+1); it never wraps.

Test Plan:
- Single request: req_valid=4'b0001, data0=8'h55, serializer busy 3..12 cycles after start -> req_ready=0001 for one cycle; tx_start one cycle later with tx_data=8'h55; tx_done one pulse after busy falls; grant_id=0.
- Round-robin fairness: all four valid continuously, bytes 8'hA0..8'hA3 -> grant order 0,1,2,3,0; each req_ready is exactly one cycle; never two bits high at once.
- Pointer wrap: after a grant to 3, valid=4'b1001 -> next grant is 0; then with valid=4'b1001 -> next grant is 3.
- Watchdog: tx_busy held 0 after tx_start, START_TO=16 -> err_timeout pulses 16 cycles after WAIT_BUSY entry; no tx_done; rr_ptr advances; a new grant is possible the next IDLE cycle.
- Late busy: tx_busy rises exactly on the expiry cycle -> no err_timeout; normal tx_done follows.
- Async reset mid-frame: rst low during WAIT_DONE -> tx_start/tx_done/err_timeout=0 and req_ready=0 immediately; after release, a pending request on 2 with rr_ptr=0 is granted to 2.
